demux4_sched: RTL
=================

# demux4_sched

Round-robin / addressed scheduler that feeds a 1:4 demultiplexer stage. It accepts a stream of WIDTH-bit items on a valid/ready input, picks a destination lane (0-3), and holds the item in a one-entry output register until that lane accepts it. Non-selected lane outputs are driven to zero, with demux semantics. It sits between a single producer and four lane consumers and owns lane selection, burst grouping, lane masking and drop accounting.

## Interface
- WIDTH, 8, item width in bits
- BURST, 4, consecutive items sent to one lane before round-robin advances (legal 1..255)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = round-robin, 1 = addressed by in_dest
- lane_en  input  4  per-lane enable mask
- in_valid  input  1  producer item valid
- in_data  input  WIDTH  producer item
- in_dest  input  2  destination lane (used only when mode=1)
- in_ready  output  1  item accepted when in_valid & in_ready
- out_valid  output  4  one-hot (or zero) lane valid
- out_data0..out_data3  output  WIDTH each  lane data; zero when that lane's out_valid is low
- out_ready  input  4  per-lane consumer ready
- drop_cnt  output  8  saturating count of dropped items

## Operation
- One clock, reset asynchronous active-low. Reset is decided as stated above.
- Reset values: out_valid=0, all out_dataN=0, drop_cnt=0, lane pointer ptr=0, burst counter cnt=0, state EMPTY. in_ready=0 while rst_n low.
- States:
  - EMPTY: no item held.
  - FULL: item held on lane L; out_valid[L]=1 and out_dataL=item.
- in_ready is combinational:
  - 0 if lane_en==0.
  - Otherwise 1 in EMPTY.
  - In FULL, in_ready = out_ready[L].
- Lane choice on acceptance in round-robin mode (mode=0):
  - If lane_en[ptr]=1, target = ptr.
  - Otherwise, target = first enabled lane after ptr in cyclic order, and cnt is treated as 0.
  - After sending, cnt is incremented. When it reaches BURST-1, cnt resets to 0 and ptr moves to the next enabled lane after target. Otherwise ptr = target.
- Lane choice on acceptance in addressed mode (mode=1):
  - target = in_dest. ptr and cnt are unchanged.
  - If lane_en[in_dest]=0, the item is accepted and discarded: no output is presented, drop_cnt increments and saturates at 255, and state is unchanged by this item.
- Transitions:
  - EMPTY -> FULL on a non-dropped acceptance.
  - FULL -> EMPTY when out_ready[L]=1 and no new acceptance.
  - FULL -> FULL with new item and lane on simultaneous release and acceptance.
  - A dropped acceptance in FULL is possible only while releasing, so it goes to EMPTY.
- mode and lane_en are sampled only at acceptance. Changing lane_en while FULL does not cancel or redirect the held item.
- Asserting rst_n low mid-transfer discards the held item immediately and returns to reset values.

## Timing
- Latency: an item accepted at rising edge N appears on out_valid/out_dataL after edge N, i.e. in cycle N+1.
- Throughput: one item per cycle while the selected consumer keeps out_ready high.
- out_valid and out_data are registered. They are stable while FULL and out_ready[L]=0.
- drop_cnt updates at the edge of the dropping acceptance.
- BURST=1 rotates lanes on every item.

## Test plan
- Reset, then mode=0, lane_en=4'b1111, BURST=4, all out_ready=1, 16 items 0x00..0x0F back-to-back -> items 0-3 on lane0, 4-7 on lane1, 8-11 on lane2, 12-15 on lane3, one per cycle, each one cycle after acceptance. Other lanes' data read 0.
- Round-robin with lane_en=4'b1010, BURST=2, 6 items -> lanes 1,1,3,3,1,1.
- Clear lane_en[1] after 1 item on lane1 -> next item goes to lane3 with cnt restarted (two items on lane3).
- Backpressure: out_ready[0]=0 for 5 cycles with item 0xA5 held -> out_valid[0] and out_data0=0xA5 stable, in_ready=0. Then raise out_ready[0] with a new item waiting -> handoff in the same cycle, no bubble.
- mode=1, lane_en=4'b0111, dests 3,2,3 -> two items dropped, drop_cnt=2, lane2 receives its item. 300 drops -> drop_cnt holds at 255.
- lane_en=0 -> in_ready=0 indefinitely. Pull rst_n low while FULL -> out_valid=0, out_data*=0 and drop_cnt=0 asynchronously. After release, the first round-robin item goes to lane0.

Source files
------------

// File: rtl/demux4_sched_if.sv
// Producer/consumer bundle for demux4_sched: one valid/ready input stream,
// four demuxed lane outputs with per-lane ready, and the drop counter.
interface demux4_sched_if #(
  parameter int unsigned WIDTH = 8
);
  logic             mode;
  logic [3:0]       lane_en;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             in_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [3:0]       out_ready;
  logic [7:0]       drop_cnt;

  modport master (
    output mode, lane_en, in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, drop_cnt
  );

  modport slave (
    input  mode, lane_en, in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, drop_cnt
  );
endinterface

// File: rtl/demux4_sched.sv
// Round-robin / addressed lane scheduler with a one-entry output register
// feeding a 1:4 demux; unselected lanes read zero, unroutable items are counted.
module demux4_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input logic             clk,
  input logic             rst_n,
  demux4_sched_if.slave   bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       lane, lane_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [7:0]       drop, drop_nx;
  logic [3:0]       vld, vld_nx;
  logic [WIDTH-1:0] dat    [4];
  logic [WIDTH-1:0] dat_nx [4];

  logic       full, rel, rdy, acc, drop_it;
  logic [1:0] target;
  logic [7:0] cnt_eff;

  // First enabled lane strictly after 'from' in cyclic order (wraps to 'from').
  function automatic logic [1:0] next_en(input logic [1:0] from, input logic [3:0] en);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = from;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!found && en[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    full     = (state == FULL);
    rel      = full && bus.out_ready[lane];
    rdy      = rst_n && (bus.lane_en != 4'b0000) && (!full || bus.out_ready[lane]);
    acc      = bus.in_valid && rdy;

    target   = ptr;
    cnt_eff  = cnt;
    drop_it  = 1'b0;
    if (bus.mode) begin
      target  = bus.in_dest;
      drop_it = !bus.lane_en[bus.in_dest];
    end else if (!bus.lane_en[ptr]) begin
      target  = next_en(ptr, bus.lane_en);
      cnt_eff = '0;
    end

    state_nx = state;
    ptr_nx   = ptr;
    lane_nx  = lane;
    cnt_nx   = cnt;
    drop_nx  = drop;
    vld_nx   = vld;
    dat_nx   = dat;

    if (acc && !drop_it) begin
      state_nx = FULL;
      lane_nx  = target;
      vld_nx   = 4'b0001 << target;
      for (int unsigned i = 0; i < 4; i++)
        dat_nx[i] = (2'(i) == target) ? bus.in_data : '0;
      if (!bus.mode) begin
        if (cnt_eff == 8'(BURST - 1)) begin
          cnt_nx = '0;
          ptr_nx = next_en(target, bus.lane_en);
        end else begin
          cnt_nx = cnt_eff + 8'd1;
          ptr_nx = target;
        end
      end
    end else begin
      // A drop while FULL implies the held item is leaving this same edge.
      if (acc)
        drop_nx = (drop == 8'hFF) ? drop : drop + 8'd1;
      if (rel) begin
        state_nx = EMPTY;
        vld_nx   = '0;
        for (int unsigned i = 0; i < 4; i++)
          dat_nx[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr   <= '0;
      lane  <= '0;
      cnt   <= '0;
      drop  <= '0;
      vld   <= '0;
      for (int unsigned i = 0; i < 4; i++)
        dat[i] <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      lane  <= lane_nx;
      cnt   <= cnt_nx;
      drop  <= drop_nx;
      vld   <= vld_nx;
      dat   <= dat_nx;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_data0 = dat[0];
  assign bus.out_data1 = dat[1];
  assign bus.out_data2 = dat[2];
  assign bus.out_data3 = dat[3];
  assign bus.drop_cnt  = drop;

endmodule
